enc_16x4_scan: RTL and testbench
================================

ENC_16X4_SCAN -- requirements
Module: enc_16x4_scan

Interface
REQ-001 The block SHALL have no parameters; input width is fixed at 16 lines and code width at 4 bits.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 En  input  1  block enable; low freezes all state.
REQ-005 Req  input  16  request lines; bit i set means line i active.
REQ-006 Load  input  1  capture Req into the pending register.
REQ-007 Ready  input  1  consumer accepts the current Code.
REQ-008 Valid  output  1  Code holds a valid encoded line index.
REQ-009 Code  output  4  index of the lowest-numbered pending line.
REQ-010 Last  output  1  the current Code is the final pending line.
REQ-011 None  output  1  one-cycle pulse: a Load captured an all-zero Req.
REQ-012 Busy  output  1  pending lines remain; Load is ignored.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-014 IDLE, En=1, Load=1, Req!=0: capture Req into a 16-bit pending register and go to SCAN; Valid SHALL rise on the next edge, giving 1-cycle latency.
REQ-015 IDLE, En=1, Load=1, Req==0: stay in IDLE, assert None for exactly one cycle, and keep Valid low.
REQ-016 In SCAN, Code SHALL equal the index of the lowest set pending bit, and Code SHALL be registered (no combinational path from Req to Code).
REQ-017 In SCAN, Valid SHALL be high whenever En=1.
REQ-018 Handshake: when Valid&&Ready are high at an edge, clear the pending bit at Code; Code SHALL advance to the next-lowest set bit on the following cycle with no bubble.
REQ-019 Valid&&!Ready SHALL hold Code, Last and pending stable (stall of any length).
REQ-020 Last SHALL be high iff exactly one pending bit remains while Valid is high.
REQ-021 A handshake while Last is high SHALL return the FSM to IDLE, with Valid and Busy low on the next cycle.
REQ-022 Busy SHALL be high exactly while the FSM is in SCAN.
REQ-023 Load while Busy SHALL be ignored; the pending register SHALL be unchanged.
REQ-024 En=0: state, pending, Code and Last SHALL be frozen; Valid and None SHALL be forced low; Ready and Load SHALL be ignored.
REQ-025 Raising En again SHALL resume from the frozen state.
REQ-026 Load and the final handshake in the same cycle: the handshake SHALL complete and the Load SHALL be ignored; a new Load is accepted only in IDLE.

Reset
REQ-027 When rst_n=0, the block SHALL immediately enter IDLE, independent of clk.
REQ-028 Reset values SHALL be: pending=0, Code=4'h0, Valid=0, Last=0, None=0, Busy=0.
REQ-029 Reset asserted mid-SCAN SHALL discard all pending lines.
REQ-030 Reset release SHALL take effect on the first clk edge with rst_n=1.

Configuration
REQ-031 The macro ENC_TRISTATE_EN SHALL control Code tri-stating.
REQ-032 With ENC_TRISTATE_EN defined, Code SHALL be driven 4'bzzzz whenever En=0 or Valid=0.
REQ-033 Without ENC_TRISTATE_EN, Code SHALL always be driven with its registered value.

Verification
REQ-034 Reset then Load with Req=16'h0090 and Ready=1 -> Code=7 (Last=0) then Code=4 is wrong; required: Code=4, Last=0, then Code=7, Last=1, then IDLE with Busy=0.
REQ-035 Load with Req=16'h0000 -> None pulses for 1 cycle, Valid stays 0, Busy stays 0.
REQ-036 Load with Req=16'h8001 and Ready=0 for 5 cycles -> Code=0 held with Valid=1; after Ready=1 -> Code=15, Last=1.
REQ-037 Load with Req=16'hFFFF and Ready=1 -> 16 consecutive handshakes with Code 0..15, Last only on 15; a second Load during SCAN is ignored.
REQ-038 Mid-SCAN: drop En for 3 cycles -> Valid=0 and Code frozen (4'bzzzz if ENC_TRISTATE_EN); restore En -> sequence resumes unchanged.
REQ-039 Assert rst_n=0 between edges during SCAN -> outputs go to reset values immediately; the next Load starts cleanly.

Source files
------------

// File: rtl/enc_16x4_scan.sv
// enc_16x4_scan: 16-line priority scan encoder with a Valid/Ready handshake.
// A Load in IDLE captures the request lines. The block then presents the
// index of each captured line, lowest first, and retires one line per
// handshake. Optional build macro: ENC_TRISTATE_EN. When it is defined,
// Code floats whenever it carries no valid index.
module enc_16x4_scan (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        En,
    input  logic [15:0] Req,
    input  logic        Load,
    input  logic        Ready,
    output logic        Valid,
    output logic [3:0]  Code,
    output logic        Last,
    output logic        None,
    output logic        Busy
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state_q;
    logic [15:0] pend_q;
    logic [3:0]  code_q;
    logic        last_q;
    logic        none_q;

    // Next-state helpers: the line set left once the current Code is retired.
    logic [15:0] rem_d;
    logic [3:0]  rem_code_d;
    logic        rem_last_d;
    logic [3:0]  cap_code_d;
    logic        cap_last_d;

    // Index of the lowest set bit. The result is 0 when no bit is set.
    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        lowest_idx = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_idx = i[3:0];
        end
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [15:0] v);
        is_onehot = (v != 16'h0) && ((v & (v - 16'd1)) == 16'h0);
    endfunction

    // Remove the line being handed over and pre-compute the next Code and Last,
    // so Code advances with no bubble.
    always_comb begin
        rem_d      = pend_q & ~(16'h0001 << code_q);
        rem_code_d = lowest_idx(rem_d);
        rem_last_d = is_onehot(rem_d);
        cap_code_d = lowest_idx(Req);
        cap_last_d = is_onehot(Req);
    end

    // Control FSM with registered Code, Last and None. En low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 16'h0;
            code_q  <= 4'h0;
            last_q  <= 1'b0;
            none_q  <= 1'b0;
        end else if (En) begin
            none_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Load) begin
                        if (Req != 16'h0) begin
                            pend_q  <= Req;
                            code_q  <= cap_code_d;
                            last_q  <= cap_last_d;
                            state_q <= SCAN;
                        end else begin
                            none_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // Load is not looked at here, so a Load during a scan is dropped.
                    if (Ready) begin
                        pend_q <= rem_d;
                        code_q <= rem_code_d;
                        last_q <= rem_last_d;
                        if (rem_d == 16'h0) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Valid and None are masked by En, so they drop at once while frozen.
    assign Busy  = (state_q == SCAN);
    assign Valid = En && (state_q == SCAN);
    assign Last  = last_q;
    assign None  = none_q && En;

`ifdef ENC_TRISTATE_EN
    // Code floats whenever it carries no valid index.
    assign Code = Valid ? code_q : 4'bzzzz;
`else
    assign Code = code_q;
`endif

endmodule

// File: tb/tb_enc_16x4_scan.sv
module tb_enc_16x4_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        En;
    logic [15:0] Req;
    logic        Load;
    logic        Ready;
    logic        Valid;
    logic [3:0]  Code;
    logic        Last;
    logic        None;
    logic        Busy;

    int total = 0;
    int bad   = 0;

    // Reference model: the lines still owed, listed in ascending order.
    int q[$];
    bit none_m = 1'b0;

    enc_16x4_scan dut (
        .clk(clk), .rst_n(rst_n), .En(En), .Req(Req), .Load(Load),
        .Ready(Ready), .Valid(Valid), .Code(Code), .Last(Last),
        .None(None), .Busy(Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        load;
        logic [15:0] req;
        logic        ready;
        logic        v;
        logic [3:0]  code;
        logic        last;
        logic        none;
        logic        busy;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Advance the model by one edge, using the inputs the DUT will see.
    function automatic void model_step();
        if (!En) return;
        none_m = 1'b0;
        if (q.size() > 0) begin
            if (Ready) void'(q.pop_front());
        end else if (Load) begin
            if (Req == 16'h0) none_m = 1'b1;
            else for (int i = 0; i < 16; i++) if (Req[i]) q.push_back(i);
        end
    endfunction

    task automatic check_model(input string tag);
        logic ev;
        ev = En && (q.size() > 0);
        chk({tag, ".valid"}, {31'b0, Valid}, {31'b0, ev});
        chk({tag, ".busy"},  {31'b0, Busy},  {31'b0, q.size() > 0});
        chk({tag, ".none"},  {31'b0, None},  {31'b0, none_m && En});
        if (ev) begin
            chk({tag, ".code"}, {28'b0, Code}, q[0]);
            chk({tag, ".last"}, {31'b0, Last}, {31'b0, q.size() == 1});
        end
`ifdef ENC_TRISTATE_EN
        else chk({tag, ".codez"}, {28'b0, Code}, {28'b0, 4'bzzzz});
`endif
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic set_in(input logic en, input logic ld, input logic [15:0] rq, input logic rd);
        En = en; Load = ld; Req = rq; Ready = rd;
    endtask

    initial begin
        logic [3:0] frozen;
        tbl[0]  = '{1'b1, 1'b1, 16'h0090, 1'b1, 1'b1, 4'd4,  1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 4'd7,  1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 16'h8001, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 4'd15, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};

        // Reset state
        rst_n = 1'b0;
        set_in(1'b1, 1'b0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", {31'b0, Valid}, 0);
        chk("rst.busy",  {31'b0, Busy},  0);
        chk("rst.last",  {31'b0, Last},  0);
        chk("rst.none",  {31'b0, None},  0);
`ifdef ENC_TRISTATE_EN
        chk("rst.code", {28'b0, Code}, {28'b0, 4'bzzzz});
`else
        chk("rst.code", {28'b0, Code}, 0);
`endif
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            set_in(tbl[i].en, tbl[i].load, tbl[i].req, tbl[i].ready);
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d.valid", i), {31'b0, Valid}, {31'b0, tbl[i].v});
            chk($sformatf("tbl%0d.busy", i),  {31'b0, Busy},  {31'b0, tbl[i].busy});
            chk($sformatf("tbl%0d.none", i),  {31'b0, None},  {31'b0, tbl[i].none});
            chk($sformatf("tbl%0d.last", i),  {31'b0, Last},  {31'b0, tbl[i].last});
`ifdef ENC_TRISTATE_EN
            if (tbl[i].v) chk($sformatf("tbl%0d.code", i), {28'b0, Code}, {28'b0, tbl[i].code});
            else chk($sformatf("tbl%0d.codez", i), {28'b0, Code}, {28'b0, 4'bzzzz});
`else
            chk($sformatf("tbl%0d.code", i), {28'b0, Code}, {28'b0, tbl[i].code});
`endif
        end

        // All 16 lines, with a stray Load mid-scan that must be dropped
        set_in(1'b1, 1'b1, 16'hFFFF, 1'b1);
        cycle("ffff.load");
        for (int k = 0; k < 16; k++) begin
            if (k == 3) set_in(1'b1, 1'b1, 16'h0001, 1'b1);
            else        set_in(1'b1, 1'b0, 16'h0000, 1'b1);
            cycle($sformatf("ffff%0d", k));
        end

        // Load together with the final handshake: the Load must be dropped
        set_in(1'b1, 1'b1, 16'h0004, 1'b0);
        cycle("lastld.load");
        set_in(1'b1, 1'b1, 16'h00F0, 1'b1);
        cycle("lastld.hs");
        set_in(1'b1, 1'b0, 16'h0000, 1'b0);
        cycle("lastld.idle");

        // Freeze mid-scan for 3 cycles, then resume
        set_in(1'b1, 1'b1, 16'h1234, 1'b1);
        cycle("frz.load");
        set_in(1'b1, 1'b0, 16'h0, 1'b1);
        cycle("frz.hs");
        frozen = Code;
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 1'b1, 16'hFFFF, 1'b1);
            cycle($sformatf("frz.off%0d", k));
`ifdef ENC_TRISTATE_EN
            chk("frz.codez", {28'b0, Code}, {28'b0, 4'bzzzz});
`else
            chk("frz.code", {28'b0, Code}, {28'b0, frozen});
`endif
        end
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 1'b0, 16'h0, 1'b1);
            cycle($sformatf("frz.on%0d", k));
        end

        // Asynchronous reset between edges during a scan
        set_in(1'b1, 1'b1, 16'hA5A0, 1'b0);
        cycle("arst.load");
        #3;
        rst_n = 1'b0;
        #1;
        q.delete();
        none_m = 1'b0;
        chk("arst.valid", {31'b0, Valid}, 0);
        chk("arst.busy",  {31'b0, Busy},  0);
        chk("arst.last",  {31'b0, Last},  0);
        chk("arst.none",  {31'b0, None},  0);
`ifdef ENC_TRISTATE_EN
        chk("arst.code", {28'b0, Code}, {28'b0, 4'bzzzz});
`else
        chk("arst.code", {28'b0, Code}, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(1'b1, 1'b1, 16'h0300, 1'b1);
        cycle("arst.reload");
        set_in(1'b1, 1'b0, 16'h0, 1'b1);
        cycle("arst.next");
        cycle("arst.done");

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [15:0] r;
            r = 16'($urandom);
            if ($urandom_range(0, 4) == 0) r = 16'h0;
            else if ($urandom_range(0, 2) == 0) r = r & 16'($urandom) & 16'($urandom);
            set_in(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0), r,
                   ($urandom_range(0, 2) != 0));
            cycle($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
